// File: rtl/camera64x64_reader.sv
// Host-side SPI master (mode 0) and frame readout controller for the 64x64 camera.
// Sends a capture command and waits for the camera interrupt with CS_N held low.
// It then reads PIX_COUNT bytes and presents each one as a single-cycle write strobe.
// PIX_COUNT exists only to shorten simulations; production uses the default of 4096.
module camera64x64_reader #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [31:0] TIMEOUT   = 32'h000249F0,
  parameter logic [7:0]  CMD       = 8'hA5,
  parameter int unsigned PIX_COUNT = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic        BUSY,
  output logic        SCLK,
  output logic        CS_N,
  output logic        MOSI,
  input  logic        MISO,
  input  logic        INT,
  output logic        PIX_VALID,
  output logic [11:0] PIX_ADDR,
  output logic [7:0]  PIX_DATA,
  output logic        DONE,
  output logic        TIMEOUT_ERR
);

  localparam int unsigned       DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [11:0]       LAST_IDX = 12'(PIX_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WAIT_INT = 3'd2,
    ST_READ     = 3'd3,
    ST_CLOSE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             last_q, last_d;
  logic [11:0]      idx_q, idx_d;
  logic [31:0]      wait_q, wait_d;
  logic             pix_valid_q, pix_valid_d;
  logic [11:0]      pix_addr_q, pix_addr_d;
  logic [7:0]       pix_data_q, pix_data_d;
  logic             done_q, done_d;
  logic             timeout_err_q, timeout_err_d;
  logic             int_meta_q, int_meta_d;
  logic             int_sync_q, int_sync_d;
  logic             tick_s;

  assign tick_s = (div_q == DIV_LAST);

  // Next-state, SPI sequencing and output computation.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    sclk_d        = sclk_q;
    cs_n_d        = cs_n_q;
    mosi_d        = mosi_q;
    busy_d        = busy_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    last_d        = last_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    pix_valid_d   = 1'b0;
    pix_addr_d    = pix_addr_q;
    pix_data_d    = pix_data_q;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    int_meta_d    = INT;
    int_sync_d    = int_meta_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_CMD;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          mosi_d     = CMD[7];
          shift_d    = CMD;
          div_d      = '0;
          bit_d      = 3'd0;
          sclk_d     = 1'b0;
          idx_d      = 12'd0;
          pix_addr_d = 12'd0;
          last_d     = 1'b0;
          wait_d     = 32'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (tick_s) begin
          div_d = '0;
          if (sclk_q) begin
            // falling edge: advance MOSI, or finish after the 8th bit
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = ST_WAIT_INT;
              mosi_d  = 1'b0;
              wait_d  = 32'd0;
            end else begin
              mosi_d  = shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
            end
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_WAIT_INT: begin
        // interrupt is checked first so it wins a same-cycle timeout
        if (int_sync_q) begin
          state_d = ST_READ;
          div_d   = '0;
          bit_d   = 3'd0;
          sclk_d  = 1'b0;
        end else if (wait_q == (TIMEOUT - 32'd1)) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
          cs_n_d        = 1'b1;
          busy_d        = 1'b0;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_READ: begin
        mosi_d = 1'b0;
        if (tick_s) begin
          div_d = '0;
          if (!sclk_q) begin
            // rising edge: sample MISO, emit a pixel every 8th bit
            sclk_d  = 1'b1;
            shift_d = {shift_q[6:0], MISO};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              pix_valid_d = 1'b1;
              pix_data_d  = {shift_q[6:0], MISO};
              pix_addr_d  = idx_q;
              if (idx_q == LAST_IDX) begin
                last_d = 1'b1;
              end else begin
                idx_d = idx_q + 12'd1;
              end
            end else begin
              last_d = last_q;
            end
          end else begin
            // falling edge: park SCLK low and close once the last pixel is out
            sclk_d = 1'b0;
            if (last_q) begin
              state_d = ST_CLOSE;
            end else begin
              state_d = ST_READ;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_CLOSE: begin
        if (tick_s) begin
          state_d = ST_IDLE;
          div_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      sclk_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      mosi_q        <= 1'b0;
      busy_q        <= 1'b0;
      bit_q         <= 3'd0;
      shift_q       <= 8'd0;
      last_q        <= 1'b0;
      idx_q         <= 12'd0;
      wait_q        <= 32'd0;
      pix_valid_q   <= 1'b0;
      pix_addr_q    <= 12'd0;
      pix_data_q    <= 8'd0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      int_meta_q    <= 1'b0;
      int_sync_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      sclk_q        <= sclk_d;
      cs_n_q        <= cs_n_d;
      mosi_q        <= mosi_d;
      busy_q        <= busy_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      last_q        <= last_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      pix_valid_q   <= pix_valid_d;
      pix_addr_q    <= pix_addr_d;
      pix_data_q    <= pix_data_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      int_meta_q    <= int_meta_d;
      int_sync_q    <= int_sync_d;
    end
  end

  assign BUSY        = busy_q;
  assign SCLK        = sclk_q;
  assign CS_N        = cs_n_q;
  assign MOSI        = mosi_q;
  assign PIX_VALID   = pix_valid_q;
  assign PIX_ADDR    = pix_addr_q;
  assign PIX_DATA    = pix_data_q;
  assign DONE        = done_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_camera64x64_reader.sv
// Scoreboard bench for camera64x64_reader with a small SPI camera model.
module tb_camera64x64_reader;

  localparam int unsigned CLK_DIV   = 2;
  localparam logic [31:0] TIMEOUT   = 32'd300;
  localparam int unsigned PIX_COUNT = 64;
  localparam int          INT_DELAY = 100;
  localparam int          BOUND     = 20000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        BUSY, SCLK, CS_N, MOSI, INT, PIX_VALID, DONE, TIMEOUT_ERR;
  logic        MISO = 1'b0;
  logic [11:0] PIX_ADDR;
  logic [7:0]  PIX_DATA;

  camera64x64_reader #(
    .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .CMD(8'hA5), .PIX_COUNT(PIX_COUNT)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .SCLK(SCLK), .CS_N(CS_N),
    .MOSI(MOSI), .MISO(MISO), .INT(INT), .PIX_VALID(PIX_VALID), .PIX_ADDR(PIX_ADDR),
    .PIX_DATA(PIX_DATA), .DONE(DONE), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          int_mode = 1;     // 0 never, 1 delayed after CS_N falls, 2 tied high
  int          cs_cnt = 0;
  int          rise_total = 0;
  logic [7:0]  cmd_cap = 8'd0;
  int          cam_r;
  logic [7:0]  cam_b;
  logic [19:0] exp_q[$];
  int          done_cnt = 0, timeout_cnt = 0, pix_cnt = 0;
  int          cyc = 0, wait_entry = 0;
  logic        sclk_prev = 1'b0;

  function automatic logic [7:0] pix_val(input int n);
    return 8'((n * 3) & 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // camera interrupt: asserted INT_DELAY cycles after CS_N falls, cleared by CS_N high
  always @(posedge CLK) cs_cnt <= CS_N ? 0 : cs_cnt + 1;
  assign INT = (int_mode == 2) || ((int_mode == 1) && !CS_N && (cs_cnt >= INT_DELAY));

  // camera SPI receiver: count SCLK rises per transaction, capture the command byte
  always @(posedge SCLK or negedge CS_N) begin
    if (SCLK) begin
      if (rise_total < 8) cmd_cap <= {cmd_cap[6:0], MOSI};
      rise_total <= rise_total + 1;
    end else begin
      rise_total <= 0;
    end
  end

  // camera SPI transmitter: next pixel bit shifted out on each falling edge
  always @(negedge SCLK) begin
    if (rise_total >= 8) begin
      cam_r = rise_total - 8;
      cam_b = pix_val(cam_r / 8);
      MISO <= cam_b[7 - (cam_r % 8)];
    end
  end

  task automatic start_frame(input bit expect_pix);
    if (expect_pix) begin
      for (int n = 0; n < PIX_COUNT; n++) exp_q.push_back({12'(n), pix_val(n)});
    end
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_end(input bit glitch);
    int d0, t0, k;
    d0 = done_cnt; t0 = timeout_cnt; k = 0;
    while (done_cnt == d0 && timeout_cnt == t0 && k < BOUND) begin
      @(posedge CLK); #1;
      START = glitch && (k == 10 || k == 60 || k == 600);
      k++;
    end
    START = 1'b0;
    if (k >= BOUND) begin
      checks++; errors++;
      $display("FAIL frame_end_wait: got no DONE/TIMEOUT_ERR within %0d cycles", BOUND);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sclk"}, SCLK, 1'b0);
    chk({tag, "_cs_n"}, CS_N, 1'b1);
    chk({tag, "_mosi"}, MOSI, 1'b0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_pix_valid"}, PIX_VALID, 1'b0);
    chk({tag, "_pix_addr"}, PIX_ADDR, 12'd0);
    chk({tag, "_pix_data"}, PIX_DATA, 8'd0);
    chk({tag, "_done"}, DONE, 1'b0);
    chk({tag, "_timeout_err"}, TIMEOUT_ERR, 1'b0);
  endtask

  initial begin
    int d0, t0, p0, k;
    logic [19:0] e;
    RST = 1'b0;
    START = 1'b0;

    // monitor: pops the scoreboard on every pixel strobe, tracks pulses and timing
    fork
      forever begin
        @(negedge CLK);
        cyc++;
        if (sclk_prev && !SCLK && rise_total == 8) wait_entry = cyc;
        sclk_prev = SCLK;
        if (PIX_VALID) begin
          pix_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pix_unexpected: got addr %0d data %0h expected no strobe", PIX_ADDR, PIX_DATA);
          end else begin
            e = exp_q.pop_front();
            chk("pix_addr", PIX_ADDR, e[19:8]);
            chk("pix_data", PIX_DATA, e[7:0]);
          end
          if (PIX_ADDR == 12'd63) chk("pix_data_63", PIX_DATA, 8'hBD);
          if (PIX_ADDR == 12'd10) chk("pix_data_10", PIX_DATA, 8'h1E);
        end
        if (DONE) begin
          done_cnt++;
          chk("done_cs_n", CS_N, 1'b1);
          chk("done_busy", BUSY, 1'b0);
        end
        if (TIMEOUT_ERR) begin
          timeout_cnt++;
          chk("timeout_latency", cyc - wait_entry, TIMEOUT);
          chk("timeout_cs_n", CS_N, 1'b1);
          chk("timeout_busy", BUSY, 1'b0);
        end
      end
    join_none

    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // normal frame, INT after a delay
    d0 = done_cnt;
    start_frame(1'b1);
    chk("start_busy", BUSY, 1'b1);
    chk("start_cs_n", CS_N, 1'b0);
    chk("start_mosi_msb", MOSI, 1'b1);
    wait_end(1'b0);
    chk("frame1_cmd_byte", cmd_cap, 8'hA5);
    chk("frame1_done_count", done_cnt - d0, 1);
    chk("frame1_queue_empty", exp_q.size(), 0);
    chk("frame1_busy_after", BUSY, 1'b0);

    // INT never arrives
    int_mode = 0;
    d0 = done_cnt; t0 = timeout_cnt; p0 = pix_cnt;
    start_frame(1'b0);
    wait_end(1'b0);
    chk("timeout_count", timeout_cnt - t0, 1);
    chk("timeout_no_done", done_cnt - d0, 0);
    chk("timeout_no_pix", pix_cnt - p0, 0);

    // INT already high before START
    int_mode = 2;
    repeat (5) @(posedge CLK);
    #1;
    d0 = done_cnt;
    start_frame(1'b1);
    wait_end(1'b0);
    chk("inthigh_done_count", done_cnt - d0, 1);
    chk("inthigh_queue_empty", exp_q.size(), 0);
    int_mode = 1;
    repeat (5) @(posedge CLK);
    #1;

    // START pulses during CMD, WAIT_INT and READ are ignored
    d0 = done_cnt;
    start_frame(1'b1);
    wait_end(1'b1);
    chk("glitch_done_count", done_cnt - d0, 1);
    chk("glitch_queue_empty", exp_q.size(), 0);
    chk("glitch_addr_held", PIX_ADDR, 12'd63);
    // back-to-back frame right after DONE restarts at index 0
    d0 = done_cnt;
    start_frame(1'b1);
    chk("restart_pix_addr", PIX_ADDR, 12'd0);
    wait_end(1'b0);
    chk("restart_done_count", done_cnt - d0, 1);
    chk("restart_queue_empty", exp_q.size(), 0);

    // reset in the middle of READ
    d0 = done_cnt; t0 = timeout_cnt; p0 = pix_cnt;
    start_frame(1'b1);
    k = 0;
    while (pix_cnt < p0 + 41 && k < BOUND) begin
      @(negedge CLK);
      k++;
    end
    if (k >= BOUND) begin
      checks++; errors++;
      $display("FAIL midread_wait: got %0d pixels expected 41", pix_cnt - p0);
    end
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(posedge CLK);
    #1;
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_no_timeout", timeout_cnt - t0, 0);
    exp_q.delete();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    d0 = done_cnt;
    start_frame(1'b1);
    wait_end(1'b0);
    chk("after_reset_done_count", done_cnt - d0, 1);
    chk("after_reset_queue_empty", exp_q.size(), 0);
    chk("after_reset_cmd_byte", cmd_cap, 8'hA5);

    repeat (4) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
